// File: rtl/unidade_controle_multiciclo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : unidade_controle_multiciclo_pkg
// Description : Shared state encoding, opcodes, ALU codes and error codes
// Revision    : 1.0 - initial release
// ============================================================================
package unidade_controle_multiciclo_pkg;

    localparam logic [2:0] c_FETCH     = 3'd0;
    localparam logic [2:0] c_DECODE    = 3'd1;
    localparam logic [2:0] c_EXECUTE   = 3'd2;
    localparam logic [2:0] c_MEMORY    = 3'd3;
    localparam logic [2:0] c_WRITEBACK = 3'd4;
    localparam logic [2:0] c_HALT      = 3'd5;

    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] c_ULA_SUB = 2'b00;
    localparam logic [1:0] c_ULA_ADD = 2'b01;
    localparam logic [1:0] c_ULA_EQ  = 2'b10;
    localparam logic [1:0] c_ULA_LT  = 2'b11;

    localparam logic [1:0] c_ERR_NONE    = 2'b00;
    localparam logic [1:0] c_ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        CLS_LOAD    = 3'd0,
        CLS_STORE   = 3'd1,
        CLS_ALU_R   = 3'd2,
        CLS_ALU_I   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_ILLEGAL = 3'd5
    } op_class_t;

endpackage
`default_nettype wire

// File: rtl/unidade_controle_multiciclo_decodificador.sv
`default_nettype none
// ============================================================================
// Module      : decodificador_instrucao
// Description : Combinational decode of latched IR fields into an op class
//               plus ALU operand/operation controls
// Revision    : 1.0 - initial release
// ============================================================================
module decodificador_instrucao
    import unidade_controle_multiciclo_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_alt,
    output logic [2:0] o_op_class,
    output logic [1:0] o_op_ula,
    output logic       o_ula_entry,
    output logic       o_sign,
    output logic       o_branch_neg
);

    always_comb begin
        o_op_class   = CLS_ILLEGAL;
        o_op_ula     = c_ULA_ADD;
        o_ula_entry  = 1'b0;
        o_sign       = 1'b0;
        o_branch_neg = 1'b0;
        case (i_opcode)
            c_OPC_LOAD:  o_op_class = CLS_LOAD;
            c_OPC_STORE: o_op_class = CLS_STORE;
            c_OPC_RTYPE: begin
                o_op_class  = CLS_ALU_R;
                o_op_ula    = i_alt ? c_ULA_SUB : c_ULA_ADD;
                o_ula_entry = 1'b1;
            end
            c_OPC_ITYPE: begin
                o_op_class  = CLS_ALU_I;
                o_op_ula    = i_alt ? c_ULA_SUB : c_ULA_ADD;
            end
            c_OPC_BRANCH: begin
                // funct3[2] selects ordering vs equality, [1] unsigned, [0] negation
                o_op_class   = (i_funct3[2:1] == 2'b01) ? CLS_ILLEGAL : CLS_BRANCH;
                o_op_ula     = i_funct3[2] ? c_ULA_LT : c_ULA_EQ;
                o_ula_entry  = 1'b1;
                o_sign       = i_funct3[2] & ~i_funct3[1];
                o_branch_neg = i_funct3[0];
            end
            default: o_op_class = CLS_ILLEGAL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/unidade_controle_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : unidade_controle_multiciclo
// Description : Multi-cycle control FSM with registered Moore outputs,
//               variable-latency memory handshake and sticky HALT trap
// Revision    : 1.0 - initial release
// ============================================================================
module unidade_controle_multiciclo
    import unidade_controle_multiciclo_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INSTR_WIDTH-1:0] instrucao,
    input  logic                   mem_ready,
    output logic                   ir_en,
    output logic                   pc_en,
    output logic                   load_en,
    output logic                   store_en,
    output logic [1:0]             op_ula,
    output logic                   operation_type,
    output logic                   ula_entry,
    output logic                   branch,
    output logic                   branch_neg,
    output logic                   sign,
    output logic                   halted,
    output logic [1:0]             err_code,
    output logic [CNT_WIDTH-1:0]   retired
);

    localparam int                     c_MEM_CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_MEM_CNT_W-1:0] c_MEM_LAST  = c_MEM_CNT_W'(MEM_TIMEOUT - 1);

    logic [2:0]             r_state;
    logic [2:0]             w_next;
    logic [6:0]             r_opcode;
    logic [2:0]             r_funct3;
    logic                   r_alt;
    logic [c_MEM_CNT_W-1:0] r_mem_cnt;
    logic [CNT_WIDTH-1:0]   r_retired;

    logic [2:0] w_dec_class;
    logic [1:0] w_dec_op_ula;
    logic       w_dec_ula_entry;
    logic       w_dec_sign;
    logic       w_dec_branch_neg;

    logic       r_ir_en, r_pc_en, r_load_en, r_store_en;
    logic [1:0] r_op_ula;
    logic       r_operation_type, r_ula_entry, r_branch, r_branch_neg, r_sign, r_halted;
    logic [1:0] r_err_code;

    logic       w_ir_en, w_pc_en, w_load_en, w_store_en;
    logic [1:0] w_op_ula;
    logic       w_operation_type, w_ula_entry, w_branch, w_branch_neg, w_sign, w_halted;
    logic [1:0] w_err_code;
    logic       w_in_instr;
    logic       w_retire;
    logic       w_unused_ir;

    assign w_unused_ir = ^{instrucao[INSTR_WIDTH-1:31], instrucao[29:15], instrucao[11:7]};

    decodificador_instrucao u_dec (
        .i_opcode     (r_opcode),
        .i_funct3     (r_funct3),
        .i_alt        (r_alt),
        .o_op_class   (w_dec_class),
        .o_op_ula     (w_dec_op_ula),
        .o_ula_entry  (w_dec_ula_entry),
        .o_sign       (w_dec_sign),
        .o_branch_neg (w_dec_branch_neg)
    );

    // State register plus the per-instruction context it needs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_FETCH;
            r_opcode  <= '0;
            r_funct3  <= '0;
            r_alt     <= 1'b0;
            r_mem_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == c_FETCH && r_ir_en) begin
                r_opcode <= instrucao[6:0];
                r_funct3 <= instrucao[14:12];
                r_alt    <= instrucao[30];
            end
            if (r_state == c_MEMORY) begin
                r_mem_cnt <= r_mem_cnt + 1'b1;
            end else begin
                r_mem_cnt <= '0;
            end
        end
    end

    // The first FETCH after reset has ir_en low, so it lingers one cycle to raise it
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_FETCH:  w_next = r_ir_en ? c_DECODE : c_FETCH;
            c_DECODE: w_next = (w_dec_class == CLS_ILLEGAL) ? c_HALT : c_EXECUTE;
            c_EXECUTE: begin
                if (w_dec_class == CLS_LOAD || w_dec_class == CLS_STORE) begin
                    w_next = c_MEMORY;
                end else if (w_dec_class == CLS_BRANCH) begin
                    w_next = c_FETCH;
                end else begin
                    w_next = c_WRITEBACK;
                end
            end
            c_MEMORY: begin
                if (mem_ready) begin
                    w_next = (w_dec_class == CLS_STORE) ? c_FETCH : c_WRITEBACK;
                end else if (r_mem_cnt == c_MEM_LAST) begin
                    w_next = c_HALT;
                end
            end
            c_WRITEBACK: w_next = c_FETCH;
            c_HALT:      w_next = c_HALT;
            default:     w_next = c_FETCH;
        endcase
    end

    always_comb begin
        w_in_instr       = (w_next == c_EXECUTE) || (w_next == c_MEMORY) || (w_next == c_WRITEBACK);
        w_ir_en          = (w_next == c_FETCH);
        w_op_ula         = w_in_instr ? w_dec_op_ula : 2'b00;
        w_ula_entry      = w_in_instr & w_dec_ula_entry;
        w_sign           = w_in_instr & w_dec_sign;
        w_branch         = (w_next == c_EXECUTE) && (w_dec_class == CLS_BRANCH);
        w_branch_neg     = w_branch & w_dec_branch_neg;
        w_store_en       = (w_next == c_MEMORY) && (w_dec_class == CLS_STORE);
        w_load_en        = (w_next == c_WRITEBACK);
        w_operation_type = (w_next == c_WRITEBACK) && (w_dec_class != CLS_LOAD);
        w_pc_en          = w_branch || (w_next == c_WRITEBACK)
                           || (r_state == c_MEMORY && w_next == c_FETCH);
        w_retire         = (w_next == c_FETCH) && ((r_state == c_EXECUTE)
                           || (r_state == c_MEMORY) || (r_state == c_WRITEBACK));
        w_halted         = 1'b0;
        w_err_code       = c_ERR_NONE;
        if (w_next == c_HALT) begin
            w_halted = 1'b1;
            if (r_state == c_HALT) begin
                w_err_code = r_err_code;
            end else if (r_state == c_MEMORY) begin
                w_err_code = c_ERR_TIMEOUT;
            end else begin
                w_err_code = c_ERR_ILLEGAL;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir_en          <= 1'b0;
            r_pc_en          <= 1'b0;
            r_load_en        <= 1'b0;
            r_store_en       <= 1'b0;
            r_op_ula         <= 2'b00;
            r_operation_type <= 1'b0;
            r_ula_entry      <= 1'b0;
            r_branch         <= 1'b0;
            r_branch_neg     <= 1'b0;
            r_sign           <= 1'b0;
            r_halted         <= 1'b0;
            r_err_code       <= c_ERR_NONE;
        end else begin
            r_ir_en          <= w_ir_en;
            r_pc_en          <= w_pc_en;
            r_load_en        <= w_load_en;
            r_store_en       <= w_store_en;
            r_op_ula         <= w_op_ula;
            r_operation_type <= w_operation_type;
            r_ula_entry      <= w_ula_entry;
            r_branch         <= w_branch;
            r_branch_neg     <= w_branch_neg;
            r_sign           <= w_sign;
            r_halted         <= w_halted;
            r_err_code       <= w_err_code;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    assign ir_en          = r_ir_en;
    assign pc_en          = r_pc_en;
    assign load_en        = r_load_en;
    assign store_en       = r_store_en;
    assign op_ula         = r_op_ula;
    assign operation_type = r_operation_type;
    assign ula_entry      = r_ula_entry;
    assign branch         = r_branch;
    assign branch_neg     = r_branch_neg;
    assign sign           = r_sign;
    assign halted         = r_halted;
    assign err_code       = r_err_code;
    assign retired        = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : tb_unidade_controle_multiciclo
// Description : Randomized self-checking bench against a per-instruction
//               cycle-trace model of the control unit
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unidade_controle_multiciclo;

    localparam int MEM_TO = 15;
    localparam int CW     = 8;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] SD = 7'b0100011;
    localparam logic [6:0] RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011;
    localparam logic [6:0] BR = 7'b1100011;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   instrucao = '0;
    logic          mem_ready = 1'b0;
    logic          ir_en, pc_en, load_en, store_en;
    logic [1:0]    op_ula;
    logic          operation_type, ula_entry, branch, branch_neg, sign, halted;
    logic [1:0]    err_code;
    logic [CW-1:0] retired;
    logic [13:0]   w_obs;

    int total = 0;
    int bad   = 0;
    logic [13:0]   q_exp[$];
    logic [13:0]   q_obs[$];
    logic [CW-1:0] q_ret[$];
    int m_count = 0;
    int m_prev  = 0;
    bit m_after_sd = 1'b0;

    always #5 clk = ~clk;

    unidade_controle_multiciclo #(
        .INSTR_WIDTH (32),
        .MEM_TIMEOUT (MEM_TO),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .instrucao      (instrucao),
        .mem_ready      (mem_ready),
        .ir_en          (ir_en),
        .pc_en          (pc_en),
        .load_en        (load_en),
        .store_en       (store_en),
        .op_ula         (op_ula),
        .operation_type (operation_type),
        .ula_entry      (ula_entry),
        .branch         (branch),
        .branch_neg     (branch_neg),
        .sign           (sign),
        .halted         (halted),
        .err_code       (err_code),
        .retired        (retired)
    );

    assign w_obs = {ir_en, pc_en, load_en, store_en, op_ula, operation_type,
                    ula_entry, branch, branch_neg, sign, halted, err_code};

    function automatic logic [13:0] pk(input bit ir, input bit pc, input bit ld, input bit st,
                                       input logic [1:0] op, input bit ot, input bit ue,
                                       input bit br, input bit bn, input bit sg, input bit h,
                                       input logic [1:0] err);
        return {ir, pc, ld, st, op, ot, ue, br, bn, sg, h, err};
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3, input bit alt,
                                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {1'b0, alt, 5'b0, rs2, rs1, f3, rd, opc};
    endfunction

    // Expected per-cycle output words for one instruction, from the instruction-level rules
    task automatic model_trace(input logic [31:0] ins, input int w);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [1:0] op;
        bit is_ld, is_sd, is_r, is_i, is_br, ue, sg, bn;
        int n_mem;
        opc   = ins[6:0];
        f3    = ins[14:12];
        is_ld = (opc == LD);
        is_sd = (opc == SD);
        is_r  = (opc == RT);
        is_i  = (opc == IT);
        is_br = (opc == BR) && (f3 != 3'b010) && (f3 != 3'b011);
        q_exp.delete();
        q_exp.push_back(pk(1, m_after_sd, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        q_exp.push_back(14'd0);
        if (!(is_ld || is_sd || is_r || is_i || is_br)) begin
            q_exp.push_back(pk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b01));
            return;
        end
        if (is_br) begin
            op = (f3 == 3'b000 || f3 == 3'b001) ? 2'b10 : 2'b11;
            sg = (f3 == 3'b100 || f3 == 3'b101);
            bn = (f3 == 3'b001 || f3 == 3'b101 || f3 == 3'b111);
            q_exp.push_back(pk(0, 1, 0, 0, op, 0, 1, 1, bn, sg, 0, 2'b00));
            return;
        end
        if (is_ld || is_sd) begin
            op = 2'b01;
            ue = 1'b0;
        end else begin
            op = ins[30] ? 2'b00 : 2'b01;
            ue = is_r;
        end
        q_exp.push_back(pk(0, 0, 0, 0, op, 0, ue, 0, 0, 0, 0, 2'b00));
        if (is_ld || is_sd) begin
            n_mem = (w > MEM_TO) ? MEM_TO : w;
            for (int k = 0; k < n_mem; k++) q_exp.push_back(pk(0, 0, 0, is_sd, op, 0, ue, 0, 0, 0, 0, 2'b00));
            if (w > MEM_TO) begin
                q_exp.push_back(pk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b10));
                return;
            end
        end
        if (!is_sd) q_exp.push_back(pk(0, 1, 1, 0, op, !is_ld, ue, 0, 0, 0, 0, 2'b00));
    endtask

    // Drives one instruction for as many cycles as the model expects, capturing outputs
    task automatic run_trace(input logic [31:0] ins, input int w);
        bit is_mem;
        int last_mem;
        is_mem   = (ins[6:0] == LD) || (ins[6:0] == SD);
        last_mem = 3 + ((w > MEM_TO) ? MEM_TO : w) - 1;
        q_obs.delete();
        q_ret.delete();
        instrucao = ins;
        for (int i = 0; i < q_exp.size(); i++) begin
            @(negedge clk);
            q_obs.push_back(w_obs);
            q_ret.push_back(retired);
            if (is_mem && i >= 3 && i <= last_mem) mem_ready = (w <= MEM_TO) && (i == last_mem);
            else mem_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic exec(input logic [31:0] ins, input int w);
        model_trace(ins, w);
        run_trace(ins, w);
        m_prev = m_count;
        if (!q_exp[q_exp.size()-1][2]) begin
            m_count    = (m_count + 1) % (1 << CW);
            m_after_sd = (ins[6:0] == SD);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_count = 0;
        m_after_sd = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (w_obs !== 14'd0 || retired !== '0) begin
            bad++;
            $display("FAIL reset_state: outputs=%b retired=%0d expected all zero", w_obs, retired);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (w_obs !== 14'd0) begin
            bad++;
            $display("FAIL reset_release: outputs=%b expected 0", w_obs);
        end
    endtask

    task automatic test_load();
        exec(mk(LD, 3'b011, 0, 5'd1, 5'd0, 5'd7), 2);
        for (int i = 0; i < q_exp.size(); i++) begin
            total++;
            if (q_obs[i] !== q_exp[i]) begin
                bad++;
                $display("FAIL load cycle %0d: got %b expected %b", i, q_obs[i], q_exp[i]);
            end
        end
        total++;
        if (q_ret[0] !== CW'(m_prev)) begin
            bad++;
            $display("FAIL load retired: got %0d expected %0d", q_ret[0], m_prev);
        end
    endtask

    task automatic test_alu();
        logic [31:0] prog[4];
        prog[0] = mk(RT, 3'b000, 0, 5'd31, 5'd7, 5'd21);
        prog[1] = mk(RT, 3'b000, 1, 5'd30, 5'd17, 5'd31);
        prog[2] = 32'h0512_8E93;   // addi x29,x5,81
        prog[3] = 32'h4512_8E93;   // same with bit 30 set: subi
        for (int n = 0; n < 4; n++) begin
            exec(prog[n], 1);
            for (int i = 0; i < q_exp.size(); i++) begin
                total++;
                if (q_obs[i] !== q_exp[i]) begin
                    bad++;
                    $display("FAIL alu[%0d] cycle %0d: got %b expected %b", n, i, q_obs[i], q_exp[i]);
                end
            end
            total++;
            if (q_ret[0] !== CW'(m_prev)) begin
                bad++;
                $display("FAIL alu[%0d] retired: got %0d expected %0d", n, q_ret[0], m_prev);
            end
        end
    endtask

    task automatic test_branches();
        logic [2:0] f3s[6];
        f3s = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        for (int n = 0; n < 6; n++) begin
            exec(mk(BR, f3s[n], 0, 5'($urandom), 5'($urandom), 5'($urandom)), 1);
            for (int i = 0; i < q_exp.size(); i++) begin
                total++;
                if (q_obs[i] !== q_exp[i]) begin
                    bad++;
                    $display("FAIL branch f3=%b cycle %0d: got %b expected %b", f3s[n], i, q_obs[i], q_exp[i]);
                end
            end
            total++;
            if (q_ret[0] !== CW'(m_prev)) begin
                bad++;
                $display("FAIL branch f3=%b retired: got %0d expected %0d", f3s[n], q_ret[0], m_prev);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] opcs[5];
        logic [2:0] bf3[6];
        logic [31:0] ins;
        logic [2:0] f3;
        opcs = '{LD, SD, RT, IT, BR};
        bf3  = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        for (int n = 0; n < 40; n++) begin
            f3  = 3'($urandom);
            ins = mk(opcs[$urandom_range(0, 4)], f3, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
            if (ins[6:0] == BR) ins[14:12] = bf3[$urandom_range(0, 5)];
            exec(ins, int'($urandom_range(1, 6)));
            for (int i = 0; i < q_exp.size(); i++) begin
                total++;
                if (q_obs[i] !== q_exp[i]) begin
                    bad++;
                    $display("FAIL random[%0d] ins=%h cycle %0d: got %b expected %b", n, ins, i, q_obs[i], q_exp[i]);
                end
            end
            total++;
            if (q_ret[0] !== CW'(m_prev)) begin
                bad++;
                $display("FAIL random[%0d] retired: got %0d expected %0d", n, q_ret[0], m_prev);
            end
        end
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b0;
        instrucao = mk(SD, 3'b011, 0, 5'd0, 5'd2, 5'd3);
        repeat (4) @(negedge clk);
        total++;
        if (store_en !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid store_before: got %b expected 1", store_en);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (w_obs !== 14'd0 || retired !== '0) begin
            bad++;
            $display("FAIL reset_mid abort: outputs=%b retired=%0d expected all zero", w_obs, retired);
        end
        @(negedge clk);
        reset = 1'b0;
        m_count = 0;
        m_after_sd = 1'b0;
        exec(mk(BR, 3'b000, 0, 5'd0, 5'd1, 5'd2), 1);
        for (int i = 0; i < q_exp.size(); i++) begin
            total++;
            if (q_obs[i] !== q_exp[i]) begin
                bad++;
                $display("FAIL reset_mid restart cycle %0d: got %b expected %b", i, q_obs[i], q_exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k <= (1 << CW); k++) begin
            exec(mk(BR, 3'b001, 0, 5'd0, 5'd4, 5'd5), 1);
            if (k == (1 << CW) - 1 || k == (1 << CW)) begin
                total++;
                if (q_ret[0] !== CW'(m_prev)) begin
                    bad++;
                    $display("FAIL wrap k=%0d retired: got %0d expected %0d", k, q_ret[0], m_prev);
                end
            end
        end
    endtask

    task automatic test_store_timeout();
        logic [31:0] prog[4];
        int ws[4];
        do_reset();
        prog[0] = mk(LD, 3'b011, 0, 5'd6, 5'd1, 5'd9);    ws[0] = MEM_TO;
        prog[1] = mk(SD, 3'b011, 0, 5'd0, 5'd1, 5'd9);    ws[1] = MEM_TO + 1;
        prog[2] = mk(7'b1111111, 3'b000, 0, 5'd1, 5'd1, 5'd1); ws[2] = 1;
        prog[3] = mk(BR, 3'b010, 0, 5'd1, 5'd1, 5'd1);   ws[3] = 1;
        for (int n = 0; n < 4; n++) begin
            if (n >= 2) do_reset();
            exec(prog[n], ws[n]);
            for (int i = 0; i < q_exp.size(); i++) begin
                total++;
                if (q_obs[i] !== q_exp[i]) begin
                    bad++;
                    $display("FAIL trap[%0d] cycle %0d: got %b expected %b", n, i, q_obs[i], q_exp[i]);
                end
            end
            total++;
            if (q_ret[0] !== CW'(m_prev)) begin
                bad++;
                $display("FAIL trap[%0d] retired: got %0d expected %0d", n, q_ret[0], m_prev);
            end
            if (n == 1) begin
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    mem_ready = 1'($urandom_range(0, 1));
                    total++;
                    if (w_obs !== pk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b10) || retired !== CW'(m_count)) begin
                        bad++;
                        $display("FAIL halt_hold cycle %0d: outputs=%b retired=%0d expected halted err=10 retired=%0d",
                                 c, w_obs, retired, m_count);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_alu();
        test_branches();
        test_random();
        test_reset_mid();
        test_wrap();
        test_store_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
